// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: EXE->MEM bundle, control bit positions,
// and the skid-register occupancy states.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;
    localparam int CTRL_W = 3;

    localparam int CTRL_REG_WE = 2;
    localparam int CTRL_MEM_RE = 1;
    localparam int CTRL_MEM_WE = 0;

    typedef struct packed {
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] store_data;
        logic [DATA_W-1:0] pc_plus2;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } exe_mem_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/exe_mem_skid_reg.sv
// EXE/MEM pipeline register with a 2-entry skid buffer so MEM backpressure
// never reaches upstream combinationally; sync flush and saturating stall count.
module exe_mem_skid_reg
    import cpu_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_alu_res,
    input  logic [DATA_W-1:0]  in_store_data,
    input  logic [DATA_W-1:0]  in_pc_plus2,
    input  logic [RD_W-1:0]    in_rd,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_alu_res,
    output logic [DATA_W-1:0]  out_store_data,
    output logic [DATA_W-1:0]  out_pc_plus2,
    output logic [RD_W-1:0]    out_rd,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    skid_state_e        state_q, state_d;
    exe_mem_t           main_q, main_d;
    exe_mem_t           skid_q, skid_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    exe_mem_t in_b;
    logic     in_fire;
    logic     out_fire;

    assign in_b = '{
        alu_res:    in_alu_res,
        store_data: in_store_data,
        pc_plus2:   in_pc_plus2,
        rd:         in_rd,
        ctrl:       in_ctrl
    };

    // in_ready depends only on the state register, never on out_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_b;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_b;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = in_b;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Payload may go stale on flush; only the state is forced.
        if (flush) begin
            state_d = EMPTY;
        end

        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_alu_res    = main_q.alu_res;
    assign out_store_data = main_q.store_data;
    assign out_pc_plus2   = main_q.pc_plus2;
    assign out_rd         = main_q.rd;
    assign out_ctrl       = main_q.ctrl;
    assign stall_cnt      = stall_q;

endmodule
